// File: rtl/bc_row_skew_feeder_pkg.sv
// Shared definitions for the BC row feeder and the processing elements it drives:
// gauss_op encodings, opcode constants, the bubble token and the feeder FSM states.
package bc_row_skew_feeder_pkg;

   // gauss_op encodings understood by the Gaussian-elimination cells
   localparam logic [1:0] GAUSS_PASS = 2'b00;
   localparam logic [1:0] GAUSS_MUL  = 2'b01;
   localparam logic [1:0] GAUSS_ADD  = 2'b10;

   // Opcode values; OP_NOP is what a bubble carries
   localparam int OP_NOP  = 0;
   localparam int OP_MAC  = 1;
   localparam int OP_ELIM = 2;
   localparam int OP_LOAD = 3;

   // Bubble token fields: no start, no-op, pass-through, zero data
   localparam logic       BUBBLE_START = 1'b0;
   localparam logic [1:0] BUBBLE_GAUSS = GAUSS_PASS;

   // Feeder control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } feed_state_t;

endpackage

// File: rtl/bc_row_skew_feeder_if.sv
// Row upstream channel. in_valid/in_ready: a row transfers on a cycle where both
// are high; in_ready is the only signal driven by the feeder.
interface bc_row_skew_feeder_if #(
   parameter int N           = 8,
   parameter int GF_BIT      = 4,
   parameter int OP_CODE_LEN = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [N*GF_BIT-1:0]     in_row;
   logic [OP_CODE_LEN-1:0]  in_op;
   logic [1:0]              in_gauss_op;
   logic                    in_start;

   modport master (output in_valid, in_row, in_op, in_gauss_op, in_start, input in_ready);
   modport slave  (input in_valid, in_row, in_op, in_gauss_op, in_start, output in_ready);
endinterface

// File: rtl/bc_row_fifo.sv
// Small synchronous row FIFO with first-word fall-through read data.
// Callers must not push when full nor pop when empty.
module bc_row_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage array: written on push, no reset needed since count gates reads
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/bc_row_skew_feeder.sv
// Feeds whole matrix rows into a linear row of BC processing elements. Rows are
// buffered, issued at most one per cycle, and column k sees its element k+1
// cycles after issue so it lines up with the control token passed along the row.
module bc_row_skew_feeder
   import bc_row_skew_feeder_pkg::*;
#(
   parameter int GF_BIT      = 4,
   parameter int OP_CODE_LEN = 4,
   parameter int N           = 8,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   bc_row_skew_feeder_if.slave       up,
   input  logic                      hold,
   output logic [N-1:0]              col_start,
   output logic [N*OP_CODE_LEN-1:0]  col_op,
   output logic [2*N-1:0]            col_gauss_op,
   output logic [N*GF_BIT-1:0]       col_data,
   output logic                      busy,
   output logic [CNT_W-1:0]          rows_issued
);
   localparam int RW = N * GF_BIT;
   localparam int EW = RW + OP_CODE_LEN + 3;
   localparam int TW = 1 + OP_CODE_LEN + 2 + GF_BIT;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(N + 1);
   localparam logic [TW-1:0] BUBBLE_TOK =
      {BUBBLE_START, OP_CODE_LEN'(OP_NOP), BUBBLE_GAUSS, GF_BIT'(0)};

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [CW-1:0]           fifo_count;
   logic [EW-1:0]           fifo_rdata;
   logic                    push;
   logic                    pop;

   logic                    iss_start;
   logic [OP_CODE_LEN-1:0]  iss_op;
   logic [1:0]              iss_gauss;
   logic [RW-1:0]           iss_row;

   feed_state_t             state;
   logic [DW-1:0]           drain_cnt;
   logic [DW-1:0]           drain_nxt;
   logic [CW-1:0]           occ_nxt;
   logic                    busy_nxt;

   // A full FIFO refuses a push even when a pop frees a slot the same cycle
   assign up.in_ready = !fifo_full;
   assign push        = up.in_valid && !fifo_full;
   assign pop         = !fifo_empty && !hold;

   bc_row_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({up.in_start, up.in_gauss_op, up.in_op, up.in_row}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Token issued this cycle: head row on a pop, otherwise a bubble
   always_comb begin
      iss_start = BUBBLE_START;
      iss_op    = OP_CODE_LEN'(OP_NOP);
      iss_gauss = BUBBLE_GAUSS;
      iss_row   = '0;
      if (pop) {iss_start, iss_gauss, iss_op, iss_row} = fifo_rdata;
   end

   // Lookahead for the FSM: the drain counter holds the number of cycles the
   // most recent issued row still occupies the skew triangle
   always_comb begin
      drain_nxt = drain_cnt;
      if (pop)                  drain_nxt = DW'(N);
      else if (drain_cnt != '0) drain_nxt = drain_cnt - DW'(1);
      occ_nxt  = fifo_count + CW'(push) - CW'(pop);
      busy_nxt = (occ_nxt != '0) || (drain_nxt != '0);
   end

   // Control FSM with drain counter and issued-row counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         drain_cnt   <= '0;
         rows_issued <= '0;
      end else begin
         drain_cnt <= drain_nxt;
         if (pop) rows_issued <= rows_issued + CNT_W'(1);
         case (state)
            ST_IDLE:  if (busy_nxt) state <= ST_RUN;
            ST_RUN:   if (!pop) state <= busy_nxt ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
               if (pop)            state <= ST_RUN;
               else if (!busy_nxt) state <= ST_IDLE;
            end
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   // Skew triangle: column k is a k+1 deep shift chain of its slice of the token
   for (genvar k = 0; k < N; k++) begin : g_col
      logic [TW-1:0] pipe [0:k];

      // Shift the column's token one stage per cycle; reset refills with bubbles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i <= k; i++) pipe[i] <= BUBBLE_TOK;
         end else begin
            pipe[0] <= {iss_start, iss_op, iss_gauss, iss_row[k*GF_BIT +: GF_BIT]};
            for (int i = 1; i <= k; i++) pipe[i] <= pipe[i-1];
         end
      end

      assign {col_start[k], col_op[k*OP_CODE_LEN +: OP_CODE_LEN],
              col_gauss_op[2*k +: 2], col_data[k*GF_BIT +: GF_BIT]} = pipe[k];
   end

endmodule

// File: tb/tb_bc_row_skew_feeder.sv
// Bench for bc_row_skew_feeder (N=4, GF_BIT=4, DEPTH=4): directed table,
// hand-written corner sequences and random traffic against a row-level model.
module tb_bc_row_skew_feeder;
   localparam int N = 4, GF_BIT = 4, OPL = 4, DEPTH = 4, CNT_W = 16;
   localparam int RW = N * GF_BIT;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               hold = 1'b0;
   logic [N-1:0]       col_start;
   logic [N*OPL-1:0]   col_op;
   logic [2*N-1:0]     col_gauss_op;
   logic [RW-1:0]      col_data;
   logic               busy;
   logic [CNT_W-1:0]   rows_issued;

   bc_row_skew_feeder_if #(.N(N), .GF_BIT(GF_BIT), .OP_CODE_LEN(OPL)) up_if ();

   bc_row_skew_feeder #(.GF_BIT(GF_BIT), .OP_CODE_LEN(OPL), .N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .up           (up_if),
      .hold         (hold),
      .col_start    (col_start),
      .col_op       (col_op),
      .col_gauss_op (col_gauss_op),
      .col_data     (col_data),
      .busy         (busy),
      .rows_issued  (rows_issued)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // reference model: row queue, issue history (newest last), counters
   typedef struct packed {
      logic           start;
      logic [OPL-1:0] op;
      logic [1:0]     g;
      logic [RW-1:0]  row;
   } tok_t;

   tok_t        fifo_q[$];
   tok_t        hist[$];
   int unsigned issued_cnt;
   int          since_pop;

   typedef struct {
      logic           valid;
      logic [RW-1:0]  row;
      logic [OPL-1:0] op;
      logic [1:0]     g;
      logic           start;
      logic           hold;
      logic [RW-1:0]  exp_data;
      logic [N*OPL-1:0] exp_op;
      logic [N-1:0]   exp_start;
      logic           exp_busy;
      logic           exp_ready;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back('0);
      issued_cnt = 0;
      since_pop  = N + 1;
   endtask

   // driver tasks
   task automatic set_in(input logic v, input logic [RW-1:0] r, input logic [OPL-1:0] o,
                         input logic [1:0] g, input logic s);
      up_if.in_valid    = v;
      up_if.in_row      = r;
      up_if.in_op       = o;
      up_if.in_gauss_op = g;
      up_if.in_start    = s;
   endtask

   task automatic idle_in();
      set_in(1'b0, '0, '0, 2'b00, 1'b0);
   endtask

   task automatic rand_row();
      set_in(1'b1, RW'($urandom), OPL'($urandom_range(1, 15)), 2'($urandom_range(0, 2)), 1'($urandom));
   endtask

   // called at negedge: compare outputs with the model, then advance across the posedge
   task automatic model_cycle();
      tok_t           t, issued, pushed;
      logic [RW-1:0]  e_data;
      logic [N*OPL-1:0] e_op;
      logic [2*N-1:0] e_g;
      logic [N-1:0]   e_st;
      logic           exp_ready, do_push, do_pop;
      for (int k = 0; k < N; k++) begin
         t = hist[hist.size()-1-k];
         e_data[k*GF_BIT +: GF_BIT] = t.row[k*GF_BIT +: GF_BIT];
         e_op[k*OPL +: OPL]         = t.op;
         e_g[2*k +: 2]              = t.g;
         e_st[k]                    = t.start;
      end
      exp_ready = (fifo_q.size() < DEPTH);
      check("in_ready", 32'(up_if.in_ready), 32'(exp_ready));
      check("col_data", 32'(col_data), 32'(e_data));
      check("col_op", 32'(col_op), 32'(e_op));
      check("col_gauss_op", 32'(col_gauss_op), 32'(e_g));
      check("col_start", 32'(col_start), 32'(e_st));
      check("busy", 32'(busy), 32'(fifo_q.size() != 0 || since_pop <= N));
      check("rows_issued", 32'(rows_issued), 32'(issued_cnt[CNT_W-1:0]));
      do_push = up_if.in_valid && exp_ready;
      do_pop  = (fifo_q.size() != 0) && !hold;
      pushed  = {up_if.in_start, up_if.in_op, up_if.in_gauss_op, up_if.in_row};
      issued  = do_pop ? fifo_q[0] : '0;
      @(posedge clk);
      #1;
      if (do_pop) begin
         void'(fifo_q.pop_front());
         issued_cnt++;
         since_pop = 1;
      end else if (since_pop <= N) begin
         since_pop++;
      end
      if (do_push) fifo_q.push_back(pushed);
      hist.push_back(issued);
      void'(hist.pop_front());
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic drain(input int cycles);
      idle_in();
      hold = 1'b0;
      repeat (cycles) step();
   endtask

   initial begin
      logic took;
      // single row 0x4321 pushed at cycle 0
      tbl[0] = '{1'b1, 16'h4321, 4'd3, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0001, 16'h0003, 4'b0001, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0020, 16'h0030, 4'b0010, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0300, 16'h0300, 4'b0100, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h4000, 16'h3000, 4'b1000, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b1};

      idle_in();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(up_if.in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rows_issued", 32'(rows_issued), 32'd0);
      check("rst_col_data", 32'(col_data), 32'd0);
      check("rst_col_op", 32'(col_op), 32'd0);
      check("rst_col_start", 32'(col_start), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed table: single row latency and busy fall
      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i].valid, tbl[i].row, tbl[i].op, tbl[i].g, tbl[i].start);
         hold = tbl[i].hold;
         @(negedge clk);
         check($sformatf("tbl%0d_data", i), 32'(col_data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_op", i), 32'(col_op), 32'(tbl[i].exp_op));
         check($sformatf("tbl%0d_start", i), 32'(col_start), 32'(tbl[i].exp_start));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
         check($sformatf("tbl%0d_ready", i), 32'(up_if.in_ready), 32'(tbl[i].exp_ready));
         model_cycle();
      end
      check("single_rows_issued", 32'(rows_issued), 32'd1);

      // six back-to-back rows
      for (int i = 0; i < 6; i++) begin
         rand_row();
         step();
      end
      drain(N + 2);
      check("b2b_rows_issued", 32'(rows_issued), 32'd7);

      // hold with a full FIFO, then release
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_row();
         step();
      end
      set_in(1'b1, 16'hBEEF, 4'd5, 2'b01, 1'b1);
      repeat (3) step();
      check("full_in_ready", 32'(up_if.in_ready), 32'd0);
      check("held_col_data", 32'(col_data), 32'd0);
      hold = 1'b0;
      took = 1'b0;
      for (int i = 0; i < 10 && !took; i++) begin
         took = (fifo_q.size() < DEPTH);
         step();
      end
      if (!took) check("fifth_accept_timeout", 32'd0, 32'd1);
      drain(N + 6);
      check("hold_rows_issued", 32'(rows_issued), 32'd12);

      // one-cycle hold pulse between rows A and B
      set_in(1'b1, 16'h1111, 4'd1, 2'b01, 1'b1);
      step();
      set_in(1'b1, 16'h2222, 4'd2, 2'b10, 1'b0);
      step();
      idle_in();
      hold = 1'b1;
      step();
      hold = 1'b0;
      drain(N + 2);

      // reset with rows in flight
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'hFFFF, 4'd7, 2'b01, 1'b1);
         step();
      end
      idle_in();
      rst_n = 1'b0;
      #2;
      check("midrst_col_data", 32'(col_data), 32'd0);
      check("midrst_col_op", 32'(col_op), 32'd0);
      check("midrst_col_start", 32'(col_start), 32'd0);
      check("midrst_col_gauss", 32'(col_gauss_op), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rows_issued", 32'(rows_issued), 32'd0);
      check("midrst_in_ready", 32'(up_if.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      step();

      // counter wrap from 0xFFFF
      hold = 1'b1;
      force dut.rows_issued = 16'hFFFF;
      #2;
      release dut.rows_issued;
      issued_cnt = 32'hFFFF;
      step();
      hold = 1'b0;
      set_in(1'b1, 16'h5A5A, 4'd4, 2'b00, 1'b1);
      step();
      idle_in();
      step();
      check("wrap_rows_issued", 32'(rows_issued), 32'd0);
      drain(N + 2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) rand_row();
         else idle_in();
         hold = ($urandom_range(0, 3) == 0);
         step();
      end
      drain(DEPTH + N + 4);
      check("final_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bc_row_skew_feeder.md
Name: bc_row_skew_feeder

Overview:
- Upstream feeder for a linear row of BC processing elements (GF multiply-accumulate and Gaussian-elimination cells) that pass control and data from one element to the next.
- Buffers whole matrix rows arriving over a valid/ready interface in a small row FIFO.
- Issues at most one row per cycle and drives column k of the array with a k-cycle skew, so each element receives its operand exactly when its left neighbour's control token arrives.
- Inserts bubble tokens whenever no row is issued. Reports busy until the last skewed token has left.

Parameters:
- GF_BIT, 4, field element width (4 or 8).
- OP_CODE_LEN, 4, opcode width carried with each row.
- N, 8, number of array columns, i.e. elements per row; must be ≥2.
- DEPTH, 4, row FIFO depth; power of two, ≥2.
- CNT_W, 16, width of the issued-row counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, row offered.
- in_ready, output, 1, FIFO can accept a row.
- in_row, input, N*GF_BIT, row elements; element k is at bits [k*GF_BIT +: GF_BIT].
- in_op, input, OP_CODE_LEN, opcode for the row.
- in_gauss_op, input, 2, gauss_op for the row.
- in_start, input, 1, start flag for the row.
- hold, input, 1, suppress issue (bubbles are inserted); skew pipeline keeps shifting.
- col_start, output, N, per-column start.
- col_op, output, N*OP_CODE_LEN, per-column opcode.
- col_gauss_op, output, 2*N, per-column gauss_op.
- col_data, output, N*GF_BIT, per-column data element.
- busy, output, 1, FIFO non-empty or any skew stage holding a non-bubble token.
- rows_issued, output, CNT_W, count of rows issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - FIFO empty; FSM IDLE; rows_issued=0; busy=0; in_ready=1.
  - Every skew stage holds a bubble, so all col_* outputs are 0.
- Bubble token: start=0, op=0, gauss_op=2'b00 (pass), data=0.
- Accept: a row is pushed when in_valid && in_ready.
  - in_ready = !full. A full FIFO refuses a push even if a pop happens the same cycle.
- Issue: a row is popped when the FIFO is non-empty && !hold; otherwise a bubble is issued that cycle.
- Skew: a token issued in cycle t appears on column k outputs in cycle t+1+k.
  - All outputs are registered.
  - Column k uses row element k together with the row's start/op/gauss_op.
  - Column 0 latency is 1 cycle from issue. Latency from push into an empty FIFO to column 0 output is 2 cycles.
- Throughput: one row per cycle sustained when rows arrive back-to-back and hold=0.
- FSM:
  - IDLE → RUN on FIFO non-empty.
  - RUN → DRAIN when FIFO empty or hold=1 and no pop this cycle; the drain counter is loaded with N.
  - DRAIN → RUN on a pop. Otherwise the counter decrements; when it reaches 0, go to IDLE.
  - busy = (state != IDLE).
- rows_issued increments on each pop; it wraps from 2^CNT_W-1 to 0.
- hold asserted mid-stream: tokens already issued keep skewing out unchanged. No partially skewed row is ever cut.
- Reset mid-operation: FIFO contents and all in-flight tokens are discarded; outputs return to bubbles immediately (asynchronously).
- Simultaneous push and pop with FIFO non-full: both take effect; occupancy is unchanged.

Decomposition:
- Shared package/define file: bubble token constant, opcode constants, and gauss_op encodings (PASS=00, MUL=01, ADD=10), shared with the processing element.
- One natural sub-module: bc_row_fifo, a DEPTH×(N*GF_BIT+OP_CODE_LEN+3) synchronous FIFO with full/empty flags.
- The skew triangle is a generate loop in the top module.

Test Plan (N=4, GF_BIT=4, DEPTH=4):
- Single row in_row=0x4321, op=3, gauss_op=00, start=1 pushed at cycle 0 → col0 data=1, op=3 at cycle 2; col1=2 at 3; col2=3 at 4; col3=4 at 5. busy falls at cycle 6. rows_issued=1.
- 6 back-to-back rows, hold=0 → in_ready never drops. col0 shows rows 0..5 in consecutive cycles with no bubbles. rows_issued=6.
- hold=1 with 4 rows pushed → in_ready=0 after the 4th push. A 5th row offered is not accepted, and col_* outputs stay bubble. Release hold → 4 rows issue on consecutive cycles; then the 5th row is accepted.
- hold pulsed for 1 cycle between rows A and B → col0 shows A, bubble (op=0, data=0), B. Column 3 shows the same pattern 3 cycles later.
- Assert rst_n=0 while 3 rows are in flight → all col_* outputs are 0 within the reset cycle. busy=0, rows_issued=0, in_ready=1.
- Preload rows_issued to 0xFFFF (force), issue 1 row → rows_issued=0x0000.
